// File: rtl/vga_pkg.sv
// Shared VGA timing constants, bus widths and the sync-bundle type for the scanout path.
// Latency: n/a (package only).
// Backpressure: n/a.
package vga_pkg;

    // 640x480@60 default timing (pixel clocks / lines)
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    // Derived totals and sync windows for the default mode
    localparam int H_TOTAL      = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;  // 800
    localparam int V_TOTAL      = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;  // 525
    localparam int H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;                            // 656
    localparam int H_SYNC_END   = H_SYNC_START + VGA_H_SYNC;                              // 752
    localparam int V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;                            // 490
    localparam int V_SYNC_END   = V_SYNC_START + VGA_V_SYNC;                              // 492

    localparam int ADDR_W = 19;
    localparam int PIX_W  = 3;

    // Sync/blank bundle carried down the delay pipe; syncs are active low.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    // One colour bit to a full-scale 8-bit DAC value.
    function automatic logic [7:0] expand_bit(input logic b);
        return {8{b}};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Stage-0 raster position: h/v counters, sync/blank decode, frame_start and in_vblank.
// Latency: all outputs are combinational from the counter registers (stage 0, undelayed).
// Backpressure: none; free-running once out of reset.
//
// Ports: clock/resetn (sync active-low); sync0 = stage-0 hs/vs/blank_n;
//        pix_next / frame_next describe the position the counters move to on the next edge;
//        frame_start pulses at h=0,v=0; in_vblank is high while v >= V_VISIBLE.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic  clock,
    input  logic  resetn,
    output sync_t sync0,
    output logic  pix_next,
    output logic  frame_next,
    output logic  frame_start,
    output logic  in_vblank
);

    localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    // run_q is low for the reset cycle itself so h=0,v=0 during reset does not
    // look like a live frame origin; the first edge after release only sets it.
    logic          run_q;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!run_q) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            h_q   <= '0;
            v_q   <= '0;
            run_q <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            run_q <= 1'b1;
        end
    end

    assign frame_next  = (h_d == '0) && (v_d == '0);
    assign pix_next    = (h_d < H_VIS) && (v_d < V_VIS);
    assign frame_start = run_q && (h_q == '0) && (v_q == '0);
    assign in_vblank   = (v_q >= V_VIS);

    assign sync0.hs      = !((h_q >= HS_BEG) && (h_q < HS_END));
    assign sync0.vs      = !((v_q >= VS_BEG) && (v_q < VS_END));
    assign sync0.blank_n = run_q && (h_q < H_VIS) && (v_q < V_VIS);

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer scanout: walks the linear pixel address, delays sync/blank to meet RAM data, drives the DAC.
// Latency: mem_raddr=A to pixel A on vga_* is READ_LATENCY+1 cycles; sync/blank carry the same delay.
// Backpressure: none; the RAM must return data exactly READ_LATENCY cycles after the address.
//
// Ports: clock/resetn (sync active-low); mem_raddr/mem_rdata = RAM read port ([2]=R,[1]=G,[0]=B);
//        vga_r/g/b, vga_hs, vga_vs (active low), vga_blank_n to the DAC;
//        frame_start, in_vblank = undelayed stage-0 status for writers.
module framebuffer_scanout
    import vga_pkg::*;
#(
    parameter int H_VISIBLE    = VGA_H_VISIBLE,
    parameter int H_FRONT      = VGA_H_FRONT,
    parameter int H_SYNC       = VGA_H_SYNC,
    parameter int H_BACK       = VGA_H_BACK,
    parameter int V_VISIBLE    = VGA_V_VISIBLE,
    parameter int V_FRONT      = VGA_V_FRONT,
    parameter int V_SYNC       = VGA_V_SYNC,
    parameter int V_BACK       = VGA_V_BACK,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              resetn,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              frame_start,
    output logic              in_vblank
);

    localparam int DEPTH = READ_LATENCY + 1;

    sync_t sync0;
    logic  pix_next;
    logic  frame_next;
    sync_t pipe_q [DEPTH];

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clock       (clock),
        .resetn      (resetn),
        .sync0       (sync0),
        .pix_next    (pix_next),
        .frame_next  (frame_next),
        .frame_start (frame_start),
        .in_vblank   (in_vblank)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            mem_raddr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= SYNC_IDLE;
            end
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else begin
            // The address register tracks the position the counters are moving to,
            // so mem_raddr always names the pixel of the current stage-0 position;
            // it holds its last value through blanking and restarts at the origin.
            if (frame_next) begin
                mem_raddr <= '0;
            end else if (pix_next) begin
                mem_raddr <= mem_raddr + 1'b1;
            end

            pipe_q[0] <= sync0;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end

            // Data for an address arrives while its sync bundle sits at DEPTH-2;
            // registering here lands colour on the same cycle as pipe_q[DEPTH-1].
            if (pipe_q[DEPTH-2].blank_n) begin
                vga_r <= expand_bit(mem_rdata[2]);
                vga_g <= expand_bit(mem_rdata[1]);
                vga_b <= expand_bit(mem_rdata[0]);
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
        end
    end

    assign vga_hs      = pipe_q[DEPTH-1].hs;
    assign vga_vs      = pipe_q[DEPTH-1].vs;
    assign vga_blank_n = pipe_q[DEPTH-1].blank_n;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench: default 640x480 instance (latency 1) plus a reduced-raster instance (latency 2).
// Latency: n/a.
// Backpressure: n/a.
module tb_framebuffer_scanout;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetn;
    int   mode;      // 0: pattern RAM, 1: all-white RAM (default instance)
    int   cyc;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Default instance: 640x480, READ_LATENCY=1
    logic [18:0] d_raddr;
    logic [2:0]  d_rdata;
    logic [7:0]  d_r, d_g, d_b;
    logic        d_hs, d_vs, d_bn, d_fs, d_vb;

    // Reduced instance: 8+2+3+3=16 cycles/line, 4+1+2+2=9 lines, READ_LATENCY=2
    logic [18:0] s_raddr;
    logic [2:0]  s_rdata, s_r1;
    logic [7:0]  s_r, s_g, s_b;
    logic        s_hs, s_vs, s_bn, s_fs, s_vb;

    framebuffer_scanout dut (
        .clock(clock), .resetn(resetn), .mem_raddr(d_raddr), .mem_rdata(d_rdata),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_hs(d_hs), .vga_vs(d_vs),
        .vga_blank_n(d_bn), .frame_start(d_fs), .in_vblank(d_vb)
    );

    framebuffer_scanout #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .READ_LATENCY(2)
    ) dut_s (
        .clock(clock), .resetn(resetn), .mem_raddr(s_raddr), .mem_rdata(s_rdata),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs),
        .vga_blank_n(s_bn), .frame_start(s_fs), .in_vblank(s_vb)
    );

    function automatic logic [2:0] d_pat(input int a, input int m);
        if (m == 1) return 3'b111;
        if (a == 0) return 3'b001;
        if (a == 1) return 3'b110;
        return 3'(a & 7);
    endfunction

    function automatic logic [23:0] rgb24(input logic [2:0] p);
        return {{8{p[2]}}, {8{p[1]}}, {8{p[0]}}};
    endfunction

    // RAM models
    always @(posedge clock) d_rdata <= d_pat(int'(d_raddr), mode);
    always @(posedge clock) begin
        s_r1    <= s_raddr[2:0] ^ 3'b101;
        s_rdata <= s_r1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_d_raddr"}, 32'(d_raddr), 0);
        chk({tag, "_d_rgb"},   32'({d_r, d_g, d_b}), 0);
        chk({tag, "_d_sync"},  32'({d_hs, d_vs, d_bn}), 32'b110);
        chk({tag, "_d_stat"},  32'({d_fs, d_vb}), 0);
        chk({tag, "_s_raddr"}, 32'(s_raddr), 0);
        chk({tag, "_s_rgb"},   32'({s_r, s_g, s_b}), 0);
        chk({tag, "_s_sync"},  32'({s_hs, s_vs, s_bn}), 32'b110);
        chk({tag, "_s_stat"},  32'({s_fs, s_vb}), 0);
    endtask

    // Entered at the sampling point of the first running cycle (h=0, v=0).
    task automatic run(input int ncyc);
        int h, v, p, hp, vp, a;
        logic bn, hs, vs;
        logic [2:0] pix;
        for (int c = 0; c < ncyc; c++) begin
            cyc = c;
            if (c == 0)   mode = 0;
            if (c == 700) mode = 1;

            // ---- default instance: stage 0 ----
            h = c % 800;
            v = c / 800;
            a = v * 640 + ((h < 640) ? h : 639);
            chk("d_raddr", 32'(d_raddr), 32'(a));
            chk("d_frame_start", 32'(d_fs), 32'(c == 0));
            chk("d_in_vblank", 32'(d_vb), 0);
            // ---- default instance: pins, 2 cycles behind ----
            if (c < 2) begin
                bn = 1'b0; hs = 1'b1;
            end else begin
                p  = c - 2;
                hp = p % 800;
                vp = p / 800;
                bn = (hp < 640);
                hs = !(hp >= 656 && hp < 752);
            end
            pix = 3'b000;
            if (bn) pix = (vp == 0) ? d_pat(hp, 0) : 3'b111;
            chk("d_blank_n", 32'(d_bn), 32'(bn));
            chk("d_hs", 32'(d_hs), 32'(hs));
            chk("d_vs", 32'(d_vs), 1);
            chk("d_rgb", 32'({d_r, d_g, d_b}), 32'(rgb24(pix)));

            // ---- reduced instance: stage 0 ----
            h = c % 16;
            v = (c / 16) % 9;
            a = (v >= 4) ? 31 : v * 8 + ((h < 8) ? h : 7);
            chk("s_raddr", 32'(s_raddr), 32'(a));
            chk("s_frame_start", 32'(s_fs), 32'(h == 0 && v == 0));
            chk("s_in_vblank", 32'(s_vb), 32'(v >= 4));
            // ---- reduced instance: pins, 3 cycles behind ----
            if (c < 3) begin
                bn = 1'b0; hs = 1'b1; vs = 1'b1; pix = 3'b000;
            end else begin
                p  = c - 3;
                hp = p % 16;
                vp = (p / 16) % 9;
                bn = (hp < 8) && (vp < 4);
                hs = !(hp >= 10 && hp < 13);
                vs = !(vp >= 5 && vp < 7);
                pix = bn ? (3'((vp * 8 + hp) & 7) ^ 3'b101) : 3'b000;
            end
            chk("s_blank_n", 32'(s_bn), 32'(bn));
            chk("s_hs", 32'(s_hs), 32'(hs));
            chk("s_vs", 32'(s_vs), 32'(vs));
            chk("s_rgb", 32'({s_r, s_g, s_b}), 32'(rgb24(pix)));

            @(negedge clock);
        end
    endtask

    initial begin
        int c;
        resetn = 1'b0;
        mode   = 0;
        cyc    = -1;
        repeat (5) @(negedge clock);
        check_idle("reset");

        resetn = 1'b1;
        @(negedge clock);
        run(1602);

        // Advance to v=2, h=5 on the reduced raster, then pulse reset for one cycle.
        c = 1602;
        while (c % 144 != 37) begin
            @(negedge clock);
            c++;
        end
        cyc = c;
        chk("pre_rst_s_raddr", 32'(s_raddr), 21);
        resetn = 1'b0;
        @(negedge clock);
        cyc = -2;
        check_idle("midrst");
        resetn = 1'b1;
        @(negedge clock);
        run(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/framebuffer_scanout.md
# framebuffer_scanout

Read side of the character framebuffer: generates 640x480@60 VGA timing, fetches one 3-bit pixel per clock from the framebuffer RAM's read port and drives RGB/sync to the DAC. It is the consumer of the pixels the typer writes: a 19-bit linear address, `y*640 + x`, and 3-bit data. It also exports a vertical-blank status that writers may use to avoid tearing.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (cycles)
- `H_SYNC`, 96, hsync pulse width
- `H_BACK`, 48, horizontal back porch
- `V_VISIBLE`, 480, visible lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width
- `V_BACK`, 33, vertical back porch
- `READ_LATENCY`, 1, framebuffer read latency in cycles (1 or 2)

Ports:
- `clock`  in  1  pixel clock (25 MHz); all logic on posedge
- `resetn`  in  1  synchronous, active-low reset
- `mem_raddr`  out  19  framebuffer read address
- `mem_rdata`  in  3  pixel data; `[2]`=R, `[1]`=G, `[0]`=B
- `vga_r`, `vga_g`, `vga_b`  out  8 each  colour; each is the data bit replicated ×8
- `vga_hs`  out  1  hsync, active low
- `vga_vs`  out  1  vsync, active low
- `vga_blank_n`  out  1  low outside the visible area
- `frame_start`  out  1  one-cycle pulse at h=0, v=0 (stage 0, undelayed)
- `in_vblank`  out  1  high while v ≥ V_VISIBLE (stage 0)

## Operation
- Stage 0 holds the counters `h` (0..799) and `v` (0..524).
  - `h` increments every cycle and wraps 799→0.
  - `v` increments when `h` wraps, and wraps 524→0.
- Address counter:
  - Increments by 1 on every cycle with h<640 and v<480; holds otherwise.
  - Cleared to 0 when the counters move to h=0, v=0.
  - No multiplier is used.
  - Maximum value is 307199; it never exceeds 19 bits.
- `mem_raddr` is registered and corresponds to the stage-0 position of the same cycle.
- Sync and blank are decoded in stage 0:
  - hs active for 656 ≤ h < 752.
  - vs active for 490 ≤ v < 492.
  - blank_n = (h<640 && v<480).
  - All three are delayed through a shift pipe of depth READ_LATENCY+1.
- Output register:
  - `vga_rgb` is the expanded `mem_rdata` when the delayed blank_n is 1, else 0.
  - `mem_rdata` outside the visible area is ignored.
- No input handshake. The RAM must return data exactly READ_LATENCY cycles after the address, with no stalls.
- Reset values, held while `resetn`=0:
  - h=0, v=0, address=0, `mem_raddr`=0.
  - RGB=0, `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0.
  - `frame_start`=0, `in_vblank`=0, all pipe stages in the blanked/inactive state.
- Reset asserted mid-frame: the frame is abandoned and all state returns to the reset values on the next edge.
  - The first cycle after release is h=0, v=0 with `frame_start`=1.

## Timing
- Line = 800 cycles; frame = 525 × 800 = 420000 cycles.
- `frame_start` period is exactly 420000 cycles.
- Latency from `mem_raddr`=A to the pixel for A on `vga_*` is READ_LATENCY+1 cycles (2 at the default).
  - hs, vs and blank_n carry the same delay, so colour and sync stay aligned.
- With the default latency, the first visible pixel of a frame appears on the pins 2 cycles after the cycle in which `frame_start` is high.
- `in_vblank` rises at h=0, v=480 and falls at h=0, v=0. Both edges are undelayed.
- Simultaneous wraps at h=799, v=524: on the next cycle h=0, v=0, address=0 and `frame_start`=1.

## Structure
- Shared package `vga_pkg`:
  - Timing constants and derived totals: H_TOTAL=800, V_TOTAL=525, sync start/end.
  - Address width 19, pixel width 3.
- Sub-module `vga_timing_gen`:
  - Contains the h/v counters, stage-0 hs/vs/blank decode, `frame_start` and `in_vblank`.
- `framebuffer_scanout` contains:
  - The address counter.
  - The delay pipe.
  - The colour expansion and output registers.

## Test plan
- Reset values: hold `resetn`=0 for 5 cycles → all outputs at their reset values; release → `frame_start`=1 and `mem_raddr`=0 on the first cycle.
- Address sweep: run one full frame with a RAM model → `mem_raddr` takes 0..307199 in order, once each, with 639→640 across the line boundary; it holds through blanking; `frame_start` recurs after exactly 420000 cycles.
- Sync alignment: measure each pulse relative to the h=0 cycle → `vga_hs` low for 96 cycles starting at h=656+2; `vga_vs` low for 1600 cycles starting at line 490; `vga_blank_n` high for exactly 640 cycles per visible line.
- Colour mapping: RAM returns 3'b001 at address 0 and 3'b110 at address 1 → first pixel is R=00, G=00, B=FF; second pixel is R=FF, G=FF, B=00.
- Blank masking: RAM drives 3'b111 everywhere → RGB=0 whenever `vga_blank_n`=0.
- Mid-frame reset: assert `resetn`=0 at v=200, h=300 for 1 cycle → reset values on the next edge; after release, timing restarts at h=0, v=0 and `mem_raddr` restarts at 0.
